// File: rtl/ccff_bitstream_loader.sv
// Serialises a valid/ready stream of bitstream words onto the configuration chain head (MSB first).
// Optional CRC-16-CCITT check of the shifted bits is enabled by defining CCFF_CRC_EN.
module ccff_bitstream_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned SL_W  = $clog2(WORD_W + 1);

`ifdef CCFF_CRC_EN
    localparam int unsigned CRC_WORDS = (16 + WORD_W - 1) / WORD_W;
    localparam int unsigned CRC_CW    = $clog2(CRC_WORDS + 1);
    localparam int unsigned ACC_W     = CRC_WORDS * WORD_W;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE, S_CRC_FETCH} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;
`endif

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [SL_W-1:0]     slice_q;
    logic [SL_W-1:0]     slice_d;
    logic [WORD_W-1:0]   shreg_q;
    logic [WORD_W-1:0]   shreg_d;
    logic                last_bit;
    int unsigned         remain;

`ifdef CCFF_CRC_EN
    logic [15:0]         crc_q;
    logic [15:0]         crc_d;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [CRC_CW-1:0]   crc_cnt_q;
    logic                crc_last;
    logic                crc_err_q;
`endif

    // Next-value helpers; slice length clips the final word to the bits still owed to the chain
    always_comb begin
        remain   = CHAIN_LEN - 32'(cnt_q);
        slice_d  = (remain >= WORD_W) ? SL_W'(WORD_W) : SL_W'(remain);
        cnt_d    = cnt_q + CNT_W'(1);
        shreg_d  = WORD_W'({shreg_q, 1'b0});
        last_bit = (cnt_q == CNT_W'(CHAIN_LEN - 1));
`ifdef CCFF_CRC_EN
        crc_d    = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ shreg_q[WORD_W-1]) ? 16'h1021 : 16'h0000);
        acc_d    = ACC_W'({acc_q, data_in});
        crc_last = (crc_cnt_q == CRC_CW'(CRC_WORDS - 1));
`endif
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            slice_q   <= '0;
            shreg_q   <= '0;
`ifdef CCFF_CRC_EN
            crc_q     <= 16'hFFFF;
            acc_q     <= '0;
            crc_cnt_q <= '0;
            crc_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_FETCH;
                        cnt_q     <= '0;
`ifdef CCFF_CRC_EN
                        crc_q     <= 16'hFFFF;
                        acc_q     <= '0;
                        crc_cnt_q <= '0;
                        crc_err_q <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (data_valid) begin
                        shreg_q <= data_in;
                        slice_q <= slice_d;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_d;
                    slice_q <= slice_q - SL_W'(1);
`ifdef CCFF_CRC_EN
                    crc_q   <= crc_d;
`endif
                    if (last_bit) begin
`ifdef CCFF_CRC_EN
                        state_q <= S_CRC_FETCH;
`else
                        state_q <= S_DONE;
`endif
                    end else if (slice_q == SL_W'(1)) begin
                        state_q <= S_FETCH;
                    end
                end
`ifdef CCFF_CRC_EN
                // Expected CRC arrives MSB word first; compare once the last word lands
                S_CRC_FETCH: begin
                    if (data_valid) begin
                        acc_q     <= acc_d;
                        crc_cnt_q <= crc_cnt_q + CRC_CW'(1);
                        if (crc_last) begin
                            crc_err_q <= (16'(acc_d) != crc_q);
                            state_q   <= S_DONE;
                        end
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Chain-facing outputs decode registered state only
    assign ccff_shift_en = (state_q == S_SHIFT);
    assign ccff_head     = (state_q == S_SHIFT) & shreg_q[WORD_W-1];
    assign done          = (state_q == S_DONE);

`ifdef CCFF_CRC_EN
    assign data_ready = (state_q == S_FETCH) || (state_q == S_CRC_FETCH);
    assign busy       = (state_q == S_FETCH) || (state_q == S_SHIFT) || (state_q == S_CRC_FETCH);
    assign crc_err    = crc_err_q;
`else
    assign data_ready = (state_q == S_FETCH);
    assign busy       = (state_q == S_FETCH) || (state_q == S_SHIFT);
    assign crc_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader: two instances (10-bit/4-bit words and 8-bit/8-bit words).
module tb_ccff_bitstream_loader;

    logic       clk;
    logic       rst;
    logic [1:0] start_v, dv_v, rdy, head, sen, busy, done, cerr;
    logic [3:0] din_a;
    logic [7:0] din_b;

    int n_chk;
    int n_fail;
    int cyc;
    int shifts [2];
    int last_sh [2];
    bit exp0 [$];
    bit exp1 [$];

    ccff_bitstream_loader #(.CHAIN_LEN(10), .WORD_W(4)) u_a (
        .prog_clk(clk), .pReset(rst), .start(start_v[0]), .data_in(din_a),
        .data_valid(dv_v[0]), .data_ready(rdy[0]), .ccff_head(head[0]),
        .ccff_shift_en(sen[0]), .busy(busy[0]), .done(done[0]), .crc_err(cerr[0])
    );

    ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_b (
        .prog_clk(clk), .pReset(rst), .start(start_v[1]), .data_in(din_b),
        .data_valid(dv_v[1]), .data_ready(rdy[1]), .ccff_head(head[1]),
        .ccff_shift_en(sen[1]), .busy(busy[1]), .done(done[1]), .crc_err(cerr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? exp0.size() : exp1.size();
    endfunction

    // Monitor: every presented chain bit is matched against the scoreboard
    always @(negedge clk) begin
        if (sen[0]) begin
            shifts[0]++;
            last_sh[0] = cyc;
            if (exp0.size() == 0) chk("head0_unexpected_shift", shifts[0], 0);
            else                  chk("head0_bit", int'(head[0]), int'(exp0.pop_front()));
        end
        if (sen[1]) begin
            shifts[1]++;
            last_sh[1] = cyc;
            if (exp1.size() == 0) chk("head1_unexpected_shift", shifts[1], 0);
            else                  chk("head1_bit", int'(head[1]), int'(exp1.pop_front()));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(int d, logic [15:0] v, int n);
        for (int k = n - 1; k >= 0; k--) begin
            if (d == 0) exp0.push_back(v[k]);
            else        exp1.push_back(v[k]);
        end
    endtask

    task automatic check_idle(int d);
        chk("idle_busy",     int'(busy[d]), 0);
        chk("idle_done",     int'(done[d]), 0);
        chk("idle_ready",    int'(rdy[d]),  0);
        chk("idle_shift_en", int'(sen[d]),  0);
        chk("idle_head",     int'(head[d]), 0);
        chk("idle_crc_err",  int'(cerr[d]), 0);
    endtask

    task automatic start_load(int d);
        shifts[d]  = 0;
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
    endtask

    task automatic feed(int d, logic [7:0] w, int stall, int exp_sen);
        for (int i = 0; i < 40 && !rdy[d]; i++) tick();
        chk("ready_wait", int'(rdy[d]), 1);
        for (int k = 0; k < stall; k++) begin
            chk("stall_ready",    int'(rdy[d]), 1);
            chk("stall_shift_en", int'(sen[d]), 0);
            tick();
        end
        if (d == 0) din_a = w[3:0];
        else        din_b = w;
        dv_v[d] = 1'b1;
        tick();
        dv_v[d] = 1'b0;
        chk("shift_after_accept", int'(sen[d]), exp_sen);
    endtask

    task automatic wait_done(int d, int exp_n);
        for (int i = 0; i < 60 && !done[d]; i++) begin
`ifdef CCFF_CRC_EN
            dv_v[d] = rdy[d] & ~sen[d];
            if (d == 0) din_a = '0;
            else        din_b = '0;
`endif
            tick();
        end
        dv_v[d] = 1'b0;
        chk("done_seen",    int'(done[d]), 1);
        chk("busy_at_done", int'(busy[d]), 0);
        chk("shift_count",  shifts[d], exp_n);
        chk("leftover_exp", qsize(d), 0);
`ifndef CCFF_CRC_EN
        chk("done_latency", cyc - last_sh[d], 1);
`endif
    endtask

    initial begin
        rst = 1'b1; start_v = '0; dv_v = '0; din_a = '0; din_b = '0;
        n_chk = 0; n_fail = 0;
        repeat (3) tick();
        check_idle(0);
        check_idle(1);
        rst = 1'b0;
        tick();

        // Basic 10-bit load, final word truncated to its two MSBs
        push(0, 16'b1010010111, 10);
        start_load(0);
        feed(0, 8'hA, 0, 1);
        feed(0, 8'h5, 0, 1);
        feed(0, 8'hC, 0, 1);
        wait_done(0, 10);
        repeat (3) tick();
        chk("done_held",     int'(done[0]), 1);
        chk("ready_in_done", int'(rdy[0]),  0);

        // Source stalls five cycles before the second word
        push(0, 16'b1010010111, 10);
        start_load(0);
        feed(0, 8'hA, 0, 1);
        feed(0, 8'h5, 5, 1);
        feed(0, 8'hC, 0, 1);
        wait_done(0, 10);

        // start during SHIFT is ignored
        push(0, 16'b1010010111, 10);
        start_load(0);
        feed(0, 8'hA, 0, 1);
        chk("busy_in_shift", int'(busy[0]), 1);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        feed(0, 8'h5, 0, 1);
        feed(0, 8'hC, 0, 1);
        wait_done(0, 10);

        // Reset after six shifts aborts the load
        push(0, 16'b101001, 6);
        start_load(0);
        feed(0, 8'hA, 0, 1);
        feed(0, 8'h5, 0, 1);
        for (int i = 0; i < 20 && shifts[0] < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle(0);
        chk("shifts_before_reset", shifts[0], 6);
        chk("reset_leftover", qsize(0), 0);
        push(0, 16'b1010010111, 10);
        start_load(0);
        feed(0, 8'hA, 0, 1);
        feed(0, 8'h5, 0, 1);
        feed(0, 8'hC, 0, 1);
        wait_done(0, 10);

        // Full-width words: all ones, then all zeros
        push(1, 16'h00FF, 8);
        start_load(1);
        feed(1, 8'hFF, 0, 1);
        wait_done(1, 8);
        push(1, 16'h0000, 8);
        start_load(1);
        feed(1, 8'h00, 0, 1);
        wait_done(1, 8);

`ifdef CCFF_CRC_EN
        // CRC-16-CCITT (init 0xFFFF) of a single 0x00 byte is 0xE1F0
        push(1, 16'h0000, 8);
        start_load(1);
        feed(1, 8'h00, 0, 1);
        feed(1, 8'hE1, 0, 0);
        feed(1, 8'hF0, 0, 0);
        chk("crc_ok_done",    int'(done[1]), 1);
        chk("crc_ok_err",     int'(cerr[1]), 0);
        chk("crc_ok_shifts",  shifts[1], 8);
        push(1, 16'h0000, 8);
        start_load(1);
        chk("crc_err_cleared", int'(cerr[1]), 0);
        feed(1, 8'h00, 0, 1);
        feed(1, 8'hE1, 0, 0);
        feed(1, 8'hF1, 0, 0);
        chk("crc_bad_done",   int'(done[1]), 1);
        chk("crc_bad_err",    int'(cerr[1]), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
